// File: rtl/matrix_result_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | matrix_result_reader                                                       |
// | Snapshots the multiplier's MxP result array and streams it out row-major   |
// | over valid/ready. Optional trailing checksum beat: RESULT_CHECKSUM_EN.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module matrix_result_reader #(
  parameter int M  = 2,
  parameter int P  = 2,
  parameter int IW = $clog2((((M > P) ? M : P) > 2) ? ((M > P) ? M : P) : 2)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [M-1:0][P-1:0][63:0]  array_c,
  input  logic                       mult_ready,
  output logic [63:0]                out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [IW-1:0]              out_row,
  output logic [IW-1:0]              out_col,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done
);

  localparam int c_num_elem = M * P;
  localparam int c_cw       = $clog2(c_num_elem + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                   r_state;
  logic                     r_armed;
  logic [c_cw-1:0]          r_idx;
  // Element 0 goes straight into out_data; r_bank[k] holds element k+1.
  logic [63:0]              r_bank [c_num_elem];
  logic [64*c_num_elem-1:0] w_flat;
  logic                     w_xfer;

  assign w_flat = array_c;
  assign w_xfer = out_valid & out_ready;
  assign busy   = out_valid;

`ifdef RESULT_CHECKSUM_EN
  logic [63:0] r_sum;
  logic        w_elem_last;
  assign w_elem_last = (r_idx == c_cw'(c_num_elem - 1));
`else
  logic [c_cw-1:0] w_idx_next;
  assign w_idx_next = r_idx + 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_armed   <= 1'b1;
      r_idx     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_row   <= '0;
      out_col   <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      for (int k = 0; k < c_num_elem; k++) r_bank[k] <= '0;
`ifdef RESULT_CHECKSUM_EN
      r_sum     <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (!mult_ready) r_armed <= 1'b1;
      case (r_state)
        IDLE: begin
          if (mult_ready && r_armed) begin
            r_armed   <= 1'b0;
            r_state   <= STREAM;
            r_idx     <= '0;
            out_valid <= 1'b1;
            out_data  <= w_flat[63:0];
            out_row   <= '0;
            out_col   <= '0;
            for (int k = 0; k < c_num_elem - 1; k++) r_bank[k] <= w_flat[64*(k+1) +: 64];
            r_bank[c_num_elem-1] <= '0;
`ifdef RESULT_CHECKSUM_EN
            out_last  <= 1'b0;
            r_sum     <= '0;
`else
            out_last  <= (c_num_elem == 1);
`endif
          end
        end
        STREAM: begin
          if (w_xfer) begin
            if (out_last) begin
              r_state   <= DONE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
            end else begin
              r_idx <= r_idx + 1'b1;
              for (int k = 0; k < c_num_elem - 1; k++) r_bank[k] <= r_bank[k+1];
              r_bank[c_num_elem-1] <= '0;
`ifdef RESULT_CHECKSUM_EN
              r_sum <= r_sum + out_data;
              if (w_elem_last) begin
                // Running sum excludes the element just sent, so add it here.
                out_data <= r_sum + out_data;
                out_row  <= '0;
                out_col  <= '0;
                out_last <= 1'b1;
              end else begin
                out_data <= r_bank[0];
                out_last <= 1'b0;
                if (out_col == IW'(P - 1)) begin
                  out_col <= '0;
                  out_row <= out_row + 1'b1;
                end else begin
                  out_col <= out_col + 1'b1;
                end
              end
`else
              out_data <= r_bank[0];
              out_last <= (w_idx_next == c_cw'(c_num_elem - 1));
              if (out_col == IW'(P - 1)) begin
                out_col <= '0;
                out_row <= out_row + 1'b1;
              end else begin
                out_col <= out_col + 1'b1;
              end
`endif
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_matrix_result_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_matrix_result_reader                                                    |
// | Directed bench with a frame-level reference model for matrix_result_reader.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_matrix_result_reader;

  localparam int M  = 2;
  localparam int P  = 2;
  localparam int IW = 1;
`ifdef RESULT_CHECKSUM_EN
  localparam bit c_ck = 1'b1;
`else
  localparam bit c_ck = 1'b0;
`endif

  logic                      clk = 1'b0;
  logic                      reset;
  logic [M-1:0][P-1:0][63:0] array_c;
  logic                      mult_ready;
  logic                      out_ready;
  logic [63:0]               out_data;
  logic                      out_valid;
  logic [IW-1:0]             out_row;
  logic [IW-1:0]             out_col;
  logic                      out_last;
  logic                      busy;
  logic                      done;

  matrix_result_reader #(.M(M), .P(P)) dut (
    .clk        (clk),
    .reset      (reset),
    .array_c    (array_c),
    .mult_ready (mult_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_row    (out_row),
    .out_col    (out_col),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0]   d;
    logic [IW-1:0] r;
    logic [IW-1:0] c;
    logic          l;
  } beat_t;

  int    checks = 0;
  int    errors = 0;
  int    n_done = 0;
  beat_t mq[$];
  beat_t lg[$];
  bit    m_armed, m_active, m_done;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: a frame is the queue of beats the sink must see.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_armed  = 1'b1;
      m_active = 1'b0;
      m_done   = 1'b0;
    end else begin
      bit          cap, fin;
      beat_t       b;
      logic [63:0] s;
      cap = !m_active && !m_done && m_armed && mult_ready;
      fin = 1'b0;
      if (m_active && out_ready) begin
        void'(mq.pop_front());
        if (mq.size() == 0) begin
          m_active = 1'b0;
          fin      = 1'b1;
        end
      end
      if (cap) begin
        s = '0;
        for (int n = 0; n < M * P; n++) begin
          b.d = array_c[n / P][n % P];
          b.r = IW'(n / P);
          b.c = IW'(n % P);
          b.l = (n == M * P - 1) && !c_ck;
          s   = s + b.d;
          mq.push_back(b);
        end
        if (c_ck) begin
          b.d = s; b.r = '0; b.c = '0; b.l = 1'b1;
          mq.push_back(b);
        end
        m_active = 1'b1;
        m_armed  = 1'b0;
      end else if (!mult_ready) begin
        m_armed = 1'b1;
      end
      m_done = fin;
    end
  end

  always @(negedge clk) begin
    beat_t b;
    chk("valid", out_valid, m_active);
    chk("busy", busy, m_active);
    chk("done", done, m_done);
    if (m_active && mq.size() > 0) begin
      chk("data", out_data, mq[0].d);
      chk("row", out_row, mq[0].r);
      chk("col", out_col, mq[0].c);
      chk("last", out_last, mq[0].l);
    end
    if (out_valid && out_ready) begin
      b.d = out_data; b.r = out_row; b.c = out_col; b.l = out_last;
      lg.push_back(b);
    end
    if (done) n_done++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_arr(input logic [63:0] a, b, c, d);
    array_c[0][0] = a; array_c[0][1] = b;
    array_c[1][0] = c; array_c[1][1] = d;
  endtask

  task automatic wait_done(input string name, input int max);
    int start;
    start = n_done;
    for (int i = 0; i < max; i++) begin
      tick(1);
      if (n_done > start) break;
    end
    chk(name, n_done > start, 1);
  endtask

  task automatic check_frame(input string name, input logic [63:0] e0, e1, e2, e3, ck);
    logic [63:0] ev [5];
    int          er [5];
    int          ec [5];
    ev = '{e0, e1, e2, e3, ck};
    er = '{0, 0, 1, 1, 0};
    ec = '{0, 1, 0, 1, 0};
    chk({name, "_len"}, lg.size(), 4 + c_ck);
    for (int n = 0; n < lg.size() && n < 5; n++) begin
      chk({name, "_data"}, lg[n].d, ev[n]);
      chk({name, "_row"}, lg[n].r, er[n]);
      chk({name, "_col"}, lg[n].c, ec[n]);
      chk({name, "_last"}, lg[n].l, (n == 3 + c_ck));
    end
  endtask

  initial begin
    reset = 1'b0; array_c = '0; mult_ready = 1'b0; out_ready = 1'b1;
    #1 reset = 1'b1;
    tick(2);
    chk("rst_data", out_data, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_row", out_row, 0);
    chk("rst_col", out_col, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;
    tick(2);

    // Basic 2x2 frame at full throughput
    set_arr(1, 2, 3, 4); lg.delete(); mult_ready = 1'b1;
    wait_done("frame1_done", 20);
    check_frame("basic", 1, 2, 3, 4, 10);
    tick(8);
    chk("no_refire", n_done, 1);

    // Re-arm, snapshot and backpressure on beat 1
    mult_ready = 1'b0; tick(1);
    lg.delete(); mult_ready = 1'b1;
    tick(1);
    set_arr('1, '1, '1, '1);
    tick(1);
    out_ready = 1'b0;
    repeat (3) begin
      tick(1);
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, 2);
      chk("stall_row", out_row, 0);
      chk("stall_col", out_col, 1);
    end
    out_ready = 1'b1;
    wait_done("frame2_done", 20);
    check_frame("bp_snap", 1, 2, 3, 4, 10);
    tick(6);
    chk("one_rearm_frame", n_done, 2);

    // Checksum wrap values
    mult_ready = 1'b0; set_arr(64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0); tick(1);
    lg.delete(); mult_ready = 1'b1;
    wait_done("frame3_done", 20);
    check_frame("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 0);

    // Reset in the middle of beat 2, mult_ready held high throughout
    mult_ready = 1'b0; set_arr(5, 6, 7, 8); tick(1);
    lg.delete(); mult_ready = 1'b1;
    tick(3);
    chk("beat2_data", out_data, 7);
    #2 reset = 1'b1;
    #1;
    chk("async_valid", out_valid, 0);
    chk("async_busy", busy, 0);
    chk("async_data", out_data, 0);
    lg.delete();
    tick(2);
    chk("no_done_on_reset", n_done, 3);
    reset = 1'b0;
    wait_done("frame4_done", 20);
    check_frame("after_reset", 5, 6, 7, 8, 26);
    tick(3);
    chk("frames_total", n_done, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/matrix_result_reader.md
# matrix_result_reader

Consumer-side unloader for the matrix multiplier's result interface. When the multiplier raises its ready level, the block snapshots the full M×P array of 64-bit results into a local register bank. It then streams the elements out one per beat, in row-major order, over a valid/ready handshake. It sits between the multiplier and the downstream sink (UART/display path on the Basys 3), so the sink never has to read the wide parallel result bus.

## Interface
- M, default 2: result rows; must be ≥1
- P, default 2: result columns; must be ≥1
- IW, default $clog2(max(M,P,2)): width of the out_row and out_col index fields (derived)

- clk  input  1  system clock, rising-edge
- reset  input  1  asynchronous, active-high; clears all state
- array_c  input  [63:0] × [M][P]  parallel result from the multiplier
- mult_ready  input  1  multiplier result-valid level; held high once results are final
- out_data  output  64  current streamed element, or the checksum beat
- out_valid  output  1  out_data and its qualifiers are valid
- out_ready  input  1  sink accepts the beat
- out_row  output  IW  row index of the current beat
- out_col  output  IW  column index of the current beat
- out_last  output  1  marks the final beat of the frame
- busy  output  1  high in STREAM
- done  output  1  one-cycle pulse after the final beat transfers

## Operation
- States: IDLE, STREAM, DONE.
- Arm flag:
  - set by reset;
  - cleared on capture;
  - re-set on any cycle where mult_ready is sampled 0.
- IDLE → STREAM when mult_ready=1 and armed=1. On that edge:
  - all M·P elements of array_c are registered into the local bank;
  - the element index is cleared to 0.
- STREAM:
  - beat n carries element (n / P, n % P), for n = 0 … M·P−1;
  - a beat transfers on a clock edge where out_valid & out_ready;
  - after a transfer, the index advances, or the block moves to DONE if that beat had out_last=1.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- Changes on array_c after capture have no effect on the frame in flight.
- Re-capture needs mult_ready to drop low first (multiplier reset). A level held high never produces a second frame.
- Index counter width: $clog2(M·P+1). The M=P=1 case is a single beat with out_last=1.

## Timing
- Reset values: out_data=0, out_valid=0, out_row=0, out_col=0, out_last=0, busy=0, done=0, state=IDLE, armed=1, bank=0.
- Reset is asynchronous. Asserting it mid-frame drops out_valid immediately. The partial frame is discarded, with no done pulse.
- Latency: mult_ready sampled high in IDLE at edge t gives out_valid=1 after edge t.
- Throughput: with out_ready held at 1, one beat per cycle. A frame takes M·P cycles (M·P+1 with the checksum), followed by one DONE cycle.
- Handshake rules:
  - out_valid never drops without a transfer;
  - out_data, out_row, out_col and out_last are stable while out_valid=1 and out_ready=0;
  - out_ready may be high at any time, including in IDLE, where it is ignored.
- out_valid is registered and carries no combinational path from out_ready.
- busy=1 exactly when out_valid=1.

## Configuration
- RESULT_CHECKSUM_EN defined:
  - one extra beat follows element (M−1,P−1);
  - out_data on this beat is the sum of all M·P elements, modulo 2^64 (wrap, no saturation);
  - out_row=0, out_col=0, out_last=1 on the checksum beat;
  - out_last is 0 on every element beat.
- RESULT_CHECKSUM_EN not defined:
  - no checksum beat and no accumulator logic;
  - out_last=1 on element (M−1,P−1).

## Test plan
- 2×2 frame, array_c={{1,2},{3,4}}, out_ready=1, mult_ready rises → beats 1,2,3,4 on consecutive cycles with (row,col)=(0,0),(0,1),(1,0),(1,1). out_last on the beat with value 4 (or on a checksum beat of 10 when RESULT_CHECKSUM_EN is defined). done pulses one cycle later.
- Backpressure: out_ready low for 3 cycles during beat 1 → out_data holds 2 with out_row=0, out_col=1, no index advance, and no beat is lost or repeated.
- Snapshot: array_c changed to all 0xFF the cycle after capture → the stream still emits 1,2,3,4.
- Checksum wrap (RESULT_CHECKSUM_EN): elements 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0 → checksum beat = 0.
- Reset at beat 2 → out_valid=0 immediately, no done pulse. Then mult_ready held at 1 through reset → a new frame starts, because reset arms the block.
- Re-arm: mult_ready held at 1 after done → no second frame. mult_ready dropped 0 for one cycle, then raised to 1 → exactly one new frame.
